// File: rtl/mdu_iterative.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MDU_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH:0]     rem;
  logic               is_div, dz, psign, qsign, rsign;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH+1:0]   diff;
  logic               last_iter;

  always_comb begin
    sgn     = ~op[0];
    a_mag   = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag   = (sgn && b[WIDTH-1]) ? -b : b;
    acc_nxt = acc + (opb[0] ? mcand : '0);
    diff    = {rem, opb[WIDTH-1]} - {2'b00, dvsr};
`ifdef MDU_EARLY_OUT_EN
    last_iter = (cnt == CNT_W'(WIDTH - 1)) || (!is_div && ((opb >> 1) == '0));
`else
    last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      opb         <= '0;
      dvsr        <= '0;
      rem         <= '0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      psign       <= 1'b0;
      qsign       <= 1'b0;
      rsign       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                state       <= CALC;
                busy        <= 1'b1;
                cnt         <= '0;
                div_by_zero <= 1'b0;
                is_div      <= op[1];
                psign       <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                qsign       <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                rsign       <= sgn & a[WIDTH-1];
                acc         <= '0;
                mcand       <= {{WIDTH{1'b0}}, a_mag};
                dvsr        <= b_mag;
                opb         <= op[1] ? a_mag : b_mag;
                dz          <= op[1] && (b == '0);
                // Divide-by-zero parks the raw dividend in rem so FIX can return it as hi.
                rem         <= (op[1] && (b == '0)) ? {1'b0, a} : '0;
              end
              3'd4:    hi <= a;
              3'd5:    lo <= a;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (dz) begin
            // Zero divisor skips every iteration; one bubble keeps completion two edges after start.
            state <= FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (is_div) begin
              rem <= diff[WIDTH+1] ? {rem[WIDTH-1:0], opb[WIDTH-1]} : diff[WIDTH:0];
              opb <= {opb[WIDTH-2:0], ~diff[WIDTH+1]};
            end else begin
              acc   <= acc_nxt;
              mcand <= mcand << 1;
              opb   <= opb >> 1;
            end
            if (last_iter) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (dz) begin
              lo          <= '1;
              hi          <= rem[WIDTH-1:0];
              div_by_zero <= 1'b1;
            end else if (is_div) begin
              lo <= qsign ? -opb : opb;
              hi <= rsign ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            end else begin
              {hi, lo} <= psign ? -acc : acc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative (WIDTH=32).
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int lat;
  int busy_gap;
  int done_seen;
  logic busy0;

  mdu_iterative #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected multiply latency in edges from start to done, given the multiplier magnitude.
  function automatic int mul_lat(input logic [31:0] m);
`ifdef MDU_EARLY_OUT_EN
    int h;
    h = 0;
    for (int i = 0; i < 32; i++) if (m[i]) h = i;
    return h + 2;
`else
    return 33;
`endif
  endfunction

  // Issue one operation and wait (bounded) for done; lat counts edges after the start edge.
  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic fl);
    op = o; a = x; b = y; start = 1'b1; flush = fl;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    busy0 = busy;
    lat = 0;
    busy_gap = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
      if (!done && !busy) busy_gap++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(3'd0, 32'd12, -32'sd34, 1'b0);
    chk("mult_busy0", busy0, 1);
    chk("mult_busy_gap", busy_gap, 0);
    chk("mult_lat", lat, mul_lat(32'd34));
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FE68);
    chk("mult_busy_end", busy, 0);

    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_lat", lat, mul_lat(32'hFFFF_FFFF));
    chk("multu_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("mult_m1_lat", lat, mul_lat(32'd1));
    chk("mult_m1_prod", {hi, lo}, 64'h0000_0000_0000_0001);

    run(3'd3, 32'd4321, 32'd1234, 1'b0);
    chk("divu_lat", lat, 33);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd619);

    run(3'd2, -32'sd7, 32'd2, 1'b0);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);

    run(3'd2, 32'd1234, 32'd0, 1'b0);
    chk("dbz_lat", lat, 2);
    chk("dbz_flag", div_by_zero, 1);
    chk("dbz_lo", lo, 32'hFFFF_FFFF);
    chk("dbz_hi", hi, 32'd1234);

    // DIVU with an MTHI request injected while busy; the request must be dropped.
    op = 3'd3; a = 32'd4321; b = 32'd1234; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("dbz_cleared", div_by_zero, 0);
    lat = 0;
    repeat (4) begin @(posedge clk); #1 lat++; end
    op = 3'd4; a = 32'h0000_DEAD; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; lat++;
    while (!done && lat < 100) begin @(posedge clk); #1 lat++; end
    chk("busy_start_lat", lat, 33);
    chk("busy_start_hi", hi, 32'd619);
    chk("busy_start_lo", lo, 32'd3);

    @(negedge clk);
    op = 3'd4; a = 32'h1234_5678; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", busy, 0);
    op = 3'd5; a = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_done", done, 0);

    // Flush on the tenth edge after start.
    op = 3'd0; a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", busy, 0);
    done_seen = 0;
    repeat (40) begin @(posedge clk); #1 if (done) done_seen++; end
    chk("flush_no_done", done_seen, 0);
    chk("flush_hi", hi, 32'h1234_5678);
    chk("flush_lo", lo, 32'h9ABC_DEF0);

    // Flush while idle must not block a same-cycle start.
    run(3'd1, 32'd5, 32'd3, 1'b1);
    chk("idle_flush_lat", lat, mul_lat(32'd3));
    chk("multu_5x3", {hi, lo}, 64'd15);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    chk("arst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(3'd1, 32'd6, 32'd7, 1'b0);
    chk("post_rst_lat", lat, mul_lat(32'd7));
    chk("post_rst_prod", {hi, lo}, 64'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised multi-cycle multiply/divide unit for the MIPS datapath. It is the sequential successor to the combinational ALU multiply.
- Computes MULT, MULTU, DIV and DIVU into architectural HI/LO registers, using a start/busy/done handshake.
- Sits beside the ALU in EX. The pipeline stalls on busy and reads hi/lo for MFHI/MFLO.
- Algorithm: one bit per cycle, shift-add for multiply, restoring for divide.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
- a  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- b  input  WIDTH  multiplier / divisor.
- flush  input  1  synchronous abort of an in-flight operation.
- busy  output  1  operation in flight; the pipeline must stall MFHI/MFLO and the next mult/div.
- done  output  1  one-cycle pulse; hi/lo were updated on the same edge.
- hi  output  WIDTH  HI register (product high half / remainder).
- lo  output  WIDTH  LO register (product low half / quotient).
- div_by_zero  output  1  sticky until the next accepted start; set by DIV/DIVU with b=0.

Behaviour:
- Reset, asynchronous when rst_n=0: state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0.
- State machine has three states: IDLE, CALC, FIX.
- IDLE, start=1, op 0-3 (edge E0):
  - Latch the operand magnitudes; signed ops take the two's-complement absolute value.
  - Latch the result signs:
    - Product sign = a[MSB]^b[MSB].
    - Quotient sign = a[MSB]^b[MSB].
    - Remainder sign = a[MSB].
  - Clear div_by_zero. Set busy=1, counter=0, state->CALC.
- IDLE, start=1, op 4/5: hi<=a (MTHI) or lo<=a (MTLO) at E0. busy and done stay 0.
- IDLE, start=1, op 6/7: ignored, with no state change.
- CALC: one iteration per edge, counter++.
  - At the edge where counter reaches WIDTH-1, state->FIX. Total is WIDTH iterations.
  - Multiply uses a 2*WIDTH-bit accumulator.
  - Divide uses a WIDTH+1-bit partial remainder.
- FIX (edge E(WIDTH+1)):
  - Apply the sign correction: negate the 2*WIDTH product, quotient or remainder as latched.
  - Write {hi,lo}.
  - Pulse done=1 for exactly one cycle. busy=0, state->IDLE.
- Latency:
  - done is high in the cycle after edge E(WIDTH+1), i.e. 33 edges after the start edge for WIDTH=32.
  - busy is high for WIDTH+1 cycles.
  - A new start is accepted in the cycle done is high.
- start while busy=1: ignored; no queueing.
- Divide by zero (DIV/DIVU with b=0):
  - Detected at E0; go directly to FIX.
  - FIX writes lo=all-ones and hi=a (raw, unsigned-corrected), and sets div_by_zero=1.
  - done follows 2 edges after E0.
- Signed overflow, DIV MIN/-1: lo=MIN, hi=0. This falls out of magnitude arithmetic; no special case.
- Multiply signedness: MULTU treats operands as unsigned. MULT returns the full signed 2*WIDTH product.
- flush=1 in CALC or FIX: state->IDLE, busy=0, done=0; hi/lo/div_by_zero keep their old values.
  - flush has priority over FIX completion.
  - flush in IDLE has no effect and does not block a same-cycle start.
- rst_n low mid-operation: immediate return to reset values.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: for MULT/MULTU, when the remaining unshifted multiplier bits are all zero, the next edge goes to FIX.
  - Latency shrinks to iterations-needed+1.
  - b=0 gives done 2 edges after start.
  - Divide latency is unchanged.
- Undefined: fixed WIDTH+1 latency for all non-zero-divisor operations, with no early-out logic.

Test Plan (WIDTH=32):
- MULT a=12, b=-34 -> hi=0xFFFFFFFF, lo=0xFFFFFE68; done exactly 33 edges after start; busy high meanwhile.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then MULT on the same operands -> hi=0, lo=1.
- DIVU a=4321, b=1234 -> lo=3, hi=619.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIV a=1234, b=0 -> div_by_zero=1, lo=0xFFFFFFFF, hi=1234, done 2 edges after start.
- Flush and reset:
  - MULT started, then flush at edge 10 -> busy=0, no done, hi/lo unchanged.
  - MULT started, rst_n low mid-CALC -> all outputs 0 asynchronously.
  - start during busy is ignored.
- Early-out, with MDU_EARLY_OUT_EN: MULTU a=5, b=3 -> lo=15, done 3 edges after start.
